// File: rtl/d05200_otp_ctrl.sv
// OTP access sequencer: boots trim words into a shadow register after reset,
// then serves single-word reads and program-verify-retry requests.
module d05200_otp_ctrl #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned T_SU       = 2,
    parameter int unsigned T_RD       = 4,
    parameter int unsigned T_HD       = 1,
    parameter int unsigned T_PROG     = 200,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned BOOT_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                prog_en,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                busy,
    output logic                boot_done,
    output logic [((BOOT_WORDS == 0) ? DATA_W : BOOT_WORDS*DATA_W)-1:0] shadow,
    output logic                otp_cs,
    output logic                otp_read,
    output logic                otp_prog,
    output logic [ADDR_W-1:0]   otp_addr,
    output logic [DATA_W-1:0]   otp_dati,
    input  logic [DATA_W-1:0]   otp_dato
);

    localparam int unsigned T_MAX_A = (T_SU > T_RD) ? T_SU : T_RD;
    localparam int unsigned T_MAX_B = (T_HD > T_PROG) ? T_HD : T_PROG;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = $clog2(T_MAX + 1);
    localparam int unsigned RT_W    = $clog2(MAX_RETRY + 1);
    localparam int unsigned IDX_W   = ADDR_W + 1;

    typedef enum logic [3:0] {
        BOOT_SU, BOOT_RD, BOOT_HD, IDLE, SU, RD, PGM, HD, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RT_W-1:0]     retry_q, retry_d;
    logic [IDX_W-1:0]    boot_idx_q, boot_idx_d;
    logic                wr_q, wr_d;
    logic                abort_q, abort_d;
    logic                vfy_q, vfy_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
    logic                prog_q, prog_d;
    logic                boot_done_d, err_d, ack_d, busy_d, cs_d, read_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   dati_d, rdata_d;
    logic                shadow_we;
    logic                su_end, rd_end, hd_end, pgm_end;

    // PROG is cut combinationally so losing VPP/unlock stops programming at once
    assign otp_prog = prog_q & prog_en;

    // Next-state, counters and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_d     = retry_q;
        boot_idx_d  = boot_idx_q;
        boot_done_d = boot_done;
        wr_d        = wr_q;
        abort_d     = abort_q;
        vfy_d       = vfy_q;
        rd_buf_d    = rd_buf_q;
        addr_d      = otp_addr;
        dati_d      = otp_dati;
        rdata_d     = rdata;
        err_d       = err;
        shadow_we   = 1'b0;

        su_end  = (cnt_q == CNT_W'(T_SU - 1));
        rd_end  = (cnt_q == CNT_W'(T_RD - 1));
        hd_end  = (cnt_q == CNT_W'(T_HD - 1));
        pgm_end = (cnt_q == CNT_W'(T_PROG - 1));

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!boot_done) begin
                    if (boot_idx_q == IDX_W'(BOOT_WORDS)) begin
                        boot_done_d = 1'b1;
                    end else begin
                        state_d = BOOT_SU;
                        addr_d  = ADDR_W'(boot_idx_q);
                        dati_d  = '0;
                    end
                end else if (req) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    vfy_d   = 1'b0;
                    retry_d = '0;
                    dati_d  = wr ? wdata : '0;
                    if (wr && !prog_en) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SU;
                    end
                end
            end
            BOOT_SU: begin
                if (su_end) begin
                    state_d = BOOT_RD;
                    cnt_d   = '0;
                end
            end
            BOOT_RD: begin
                if (rd_end) begin
                    shadow_we = 1'b1;
                    state_d   = BOOT_HD;
                    cnt_d     = '0;
                end
            end
            BOOT_HD: begin
                if (hd_end) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    boot_idx_d = boot_idx_q + IDX_W'(1);
                    if (boot_idx_q == IDX_W'(BOOT_WORDS - 1)) boot_done_d = 1'b1;
                end
            end
            SU, PGM, RD: begin
                if (wr_q && !prog_en) begin
                    state_d = HD;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (state_q == SU && su_end) begin
                    state_d = wr_q ? PGM : RD;
                    cnt_d   = '0;
                end else if (state_q == PGM && pgm_end) begin
                    state_d = HD;
                    cnt_d   = '0;
                end else if (state_q == RD && rd_end) begin
                    rd_buf_d = otp_dato;
                    state_d  = HD;
                    cnt_d    = '0;
                end
            end
            HD: begin
                if (wr_q && !prog_en) abort_d = 1'b1;
                if (hd_end) begin
                    cnt_d = '0;
                    if (!wr_q) begin
                        state_d = DONE;
                        rdata_d = rd_buf_q;
                    end else if (abort_q || !prog_en) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (!vfy_q) begin
                        state_d = RD;
                        vfy_d   = 1'b1;
                    end else if ((rd_buf_q & otp_dati) == otp_dati) begin
                        state_d = DONE;
                        rdata_d = rd_buf_q;
                    end else begin
                        retry_d = retry_q + RT_W'(1);
                        if ((retry_q + RT_W'(1)) < RT_W'(MAX_RETRY)) begin
                            state_d = SU;
                            vfy_d   = 1'b0;
                        end else begin
                            state_d = DONE;
                            rdata_d = rd_buf_q;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_d   = state_d inside {BOOT_SU, BOOT_RD, BOOT_HD, SU, RD, PGM, HD};
        read_d = state_d inside {BOOT_RD, RD};
        prog_d = (state_d == PGM);
        ack_d  = (state_d == DONE);
        busy_d = !boot_done_d || (state_d inside {SU, RD, PGM, HD});
    end

    // State, sequencing registers, registered outputs and shadow capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            boot_idx_q <= '0;
            wr_q       <= 1'b0;
            abort_q    <= 1'b0;
            vfy_q      <= 1'b0;
            rd_buf_q   <= '0;
            prog_q     <= 1'b0;
            boot_done  <= 1'b0;
            err        <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            otp_cs     <= 1'b0;
            otp_read   <= 1'b0;
            otp_addr   <= '0;
            otp_dati   <= '0;
            rdata      <= '0;
            shadow     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            boot_idx_q <= boot_idx_d;
            wr_q       <= wr_d;
            abort_q    <= abort_d;
            vfy_q      <= vfy_d;
            rd_buf_q   <= rd_buf_d;
            prog_q     <= prog_d;
            boot_done  <= boot_done_d;
            err        <= err_d;
            ack        <= ack_d;
            busy       <= busy_d;
            otp_cs     <= cs_d;
            otp_read   <= read_d;
            otp_addr   <= addr_d;
            otp_dati   <= dati_d;
            rdata      <= rdata_d;
            if (shadow_we) begin
                for (int unsigned k = 0; k < BOOT_WORDS; k++) begin
                    if (boot_idx_q == IDX_W'(k)) shadow[k*DATA_W +: DATA_W] <= otp_dato;
                end
            end
        end
    end

endmodule

// File: tb/tb_d05200_otp_ctrl.sv
// Bench for d05200_otp_ctrl: OTP macro model, ACK scoreboard, timing checks.
module tb_d05200_otp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wr, prog_en;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        ack, err, busy, boot_done;
    logic [7:0]  rdata;
    logic [31:0] shadow;
    logic        otp_cs, otp_read, otp_prog;
    logic [6:0]  otp_addr;
    logic [7:0]  otp_dati, otp_dato;

    d05200_otp_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .prog_en(prog_en), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .boot_done(boot_done), .shadow(shadow), .otp_cs(otp_cs), .otp_read(otp_read),
        .otp_prog(otp_prog), .otp_addr(otp_addr), .otp_dati(otp_dati), .otp_dato(otp_dato)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // OTP macro model: base contents, programmed bits, and bits that refuse to program
    bit [7:0] base  [128];
    bit [7:0] progd [128];
    bit [7:0] lock  [128];
    always_comb otp_dato = (otp_cs && otp_read) ? (base[otp_addr] | progd[otp_addr]) : 8'h00;
    always @(posedge clk) if (otp_cs && otp_prog) progd[otp_addr] <= progd[otp_addr] | (otp_dati & ~lock[otp_addr]);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct { logic [7:0] rd; logic err; int cyc; } exp_t;
    exp_t sb[$];
    exp_t e;

    int cs_cycles = 0, prog_cycles = 0, prog_pulses = 0, rd_cycles = 0, rd_last = 0;
    logic prog_prev = 1'b0;

    // Per-cycle monitor: control invariants, activity counters, ACK scoreboard
    always @(negedge clk) begin
        check("rd_pr_excl", 64'(otp_read & otp_prog), 64'd0);
        check("ctl_without_cs", 64'((otp_read | otp_prog) & ~otp_cs), 64'd0);
        if (otp_cs) cs_cycles++;
        if (otp_read) begin rd_cycles++; rd_last = cyc; end
        if (otp_prog) begin prog_cycles++; if (!prog_prev) prog_pulses++; end
        prog_prev = otp_prog;
        if (rst_n && ack) begin
            if (sb.size() == 0) check("ack_unexpected", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
                check("ack_rdata", 64'(rdata), 64'(e.rd));
                check("ack_err", 64'(err), 64'(e.err));
                check("ack_busy", 64'(busy), 64'd0);
            end
        end
    end

    int acc_cyc;

    task automatic wait_sb(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            check("ack_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_req(input logic w, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] x_rd, input logic x_err, input int lat);
        @(posedge clk); #1;
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        acc_cyc = cyc;
        sb.push_back('{x_rd, x_err, cyc + lat - 1});
        if (lat > 1) check("busy_after_acc", 64'(busy), 64'd1);
        wait_sb(lat + 50);
    endtask

    task automatic wait_boot(input logic [31:0] x_shadow);
        int n;
        n = 0;
        while (!boot_done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) check("boot_busy", 64'(busy), 64'd1);
        end
        check("boot_cycles", 64'(n), 64'd32);
        check("boot_shadow", 64'(shadow), 64'(x_shadow));
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, 64'({ack, err, busy, boot_done, otp_cs, otp_read, otp_prog,
                        rdata, otp_addr, otp_dati, shadow}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, p0, n0, r0;
        rst_n = 1'b0; req = 1'b1; wr = 1'b0; addr = 7'h03; wdata = 8'h00; prog_en = 1'b1;
        base[0] = 8'h11; base[1] = 8'h22; base[2] = 8'h33; base[3] = 8'h44;
        base[7'h7F] = 8'hA5;
        base[7'h20] = 8'h7F; lock[7'h20] = 8'h80;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset_outs");
        rst_n = 1'b1;

        // Boot with REQ held high: only accepted once BOOT_DONE is up
        wait_boot(32'h44332211);
        @(posedge clk); #1;
        req = 1'b0;
        sb.push_back('{8'h44, 1'b0, cyc + 7});
        wait_sb(60);

        // Plain read, check READ window
        r0 = rd_cycles;
        do_req(1'b0, 7'h7F, 8'h00, 8'hA5, 1'b0, 8);
        check("rd_last_cycle", 64'(rd_last), 64'(acc_cyc + 5));
        check("rd_width", 64'(rd_cycles - r0), 64'd4);

        // Program a blank cell: one 200-cycle pulse, verify passes
        p0 = prog_cycles; n0 = prog_pulses;
        do_req(1'b1, 7'h10, 8'h5A, 8'h5A, 1'b0, 209);
        check("pgm_cycles", 64'(prog_cycles - p0), 64'd200);
        check("pgm_pulses", 64'(prog_pulses - n0), 64'd1);
        check("pgm_cell", 64'(base[7'h10] | progd[7'h10]), 64'h5A);

        // Program a stuck cell: three attempts then error
        p0 = prog_cycles; n0 = prog_pulses;
        do_req(1'b1, 7'h20, 8'hFF, 8'h7F, 1'b1, 3 * 208 + 1);
        check("stuck_cycles", 64'(prog_cycles - p0), 64'd600);
        check("stuck_pulses", 64'(prog_pulses - n0), 64'd3);

        // Program refused with PROG_EN low: no macro activity, RDATA unchanged
        prog_en = 1'b0;
        c0 = cs_cycles; p0 = prog_cycles;
        do_req(1'b1, 7'h30, 8'h12, 8'h7F, 1'b1, 1);
        check("noen_cs", 64'(cs_cycles - c0), 64'd0);
        check("noen_prog", 64'(prog_cycles - p0), 64'd0);
        prog_en = 1'b1;

        // PROG_EN dropped mid-PGM
        p0 = prog_cycles; n0 = prog_pulses;
        fork
            do_req(1'b1, 7'h40, 8'h33, 8'h7F, 1'b1, 25);
            begin : drop_en
                int n;
                n = 0;
                while (!otp_prog && n < 100) begin @(negedge clk); n++; end
                check("abort_prog_seen", 64'(otp_prog), 64'd1);
                repeat (20) @(posedge clk);
                #1 prog_en = 1'b0;
                #1 check("abort_prog_drop", 64'(otp_prog), 64'd0);
                check("abort_cs_held", 64'(otp_cs), 64'd1);
            end
        join
        check("abort_cycles", 64'(prog_cycles - p0), 64'd20);
        check("abort_pulses", 64'(prog_pulses - n0), 64'd1);
        prog_en = 1'b1;

        // Reset mid-PGM: controls drop without a clock edge, boot reloads shadow
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; addr = 7'h50; wdata = 8'h0F;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (20) @(posedge clk);
        #2 check("pgm_before_rst", 64'(otp_prog), 64'd1);
        rst_n = 1'b0;
        #1 check("rst_prog_async", 64'(otp_prog), 64'd0);
        check("rst_cs_async", 64'(otp_cs), 64'd0);
        check_reset_outs("rst_outs_mid");
        base[1] = 8'h2A;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_boot(32'h44332A11);

        // Back-to-back: REQ held through the ACK cycle is accepted there
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; addr = 7'h02;
        @(posedge clk); #1;
        acc_cyc = cyc;
        sb.push_back('{8'h33, 1'b0, acc_cyc + 7});
        addr = 7'h7F;
        repeat (8) @(posedge clk);
        #1 req = 1'b0;
        sb.push_back('{8'hA5, 1'b0, acc_cyc + 15});
        wait_sb(60);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
